// File: rtl/mem_stage.sv
// MEM pipeline stage: latches the EX result, runs loads/stores over a req/ready
// data-memory handshake, formats load data and drives the MEM forwarding and
// writeback ports. Upstream is stalled while a memory access is outstanding.
module mem_stage #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            ex_valid_i,
    input  logic [4:0]      ex_rd_i,
    input  logic [XLEN-1:0] ex_alu_res_i,
    input  logic            ex_load_i,
    input  logic            ex_store_i,
    input  logic [2:0]      ex_funct3_i,
    input  logic [XLEN-1:0] ex_store_value_i,
    output logic            stall_o,
    output logic            load_pending_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [7:0]      mem_wmask_o,
    input  logic            mem_ready_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            misaligned_o,
    output logic [4:0]      fwd_rd_o,
    output logic [XLEN-1:0] fwd_res_o,
    output logic            wb_valid_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o
);

    typedef enum logic [0:0] {StIdle, StBus} state_e;

    state_e          state_q, state_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [7:0]      wmask_q, wmask_d;
    logic            is_load_q, is_load_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [2:0]      lane_q, lane_d;
    logic [4:0]      rd_q, rd_d;
    logic            mis_q, mis_d;
    logic            wb_valid_q, wb_valid_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;

    logic [2:0]      ex_lane;
    logic            ex_aligned;
    logic [XLEN-1:0] st_wdata;
    logic [7:0]      st_wmask;
    logic [XLEN-1:0] rd_shifted;
    logic [XLEN-1:0] ld_data;

    assign ex_lane = ex_alu_res_i[2:0];

    // Natural alignment check and store lane placement for the incoming access
    always_comb begin
        ex_aligned = 1'b1;
        st_wdata   = ex_store_value_i;
        st_wmask   = 8'hFF;
        case (ex_funct3_i[1:0])
            2'b00: begin
                st_wdata = {8{ex_store_value_i[7:0]}};
                st_wmask = 8'h01 << ex_lane;
            end
            2'b01: begin
                ex_aligned = (ex_lane[0] == 1'b0);
                st_wdata   = {4{ex_store_value_i[15:0]}};
                st_wmask   = 8'h03 << ex_lane;
            end
            2'b10: begin
                ex_aligned = (ex_lane[1:0] == 2'b00);
                st_wdata   = {2{ex_store_value_i[31:0]}};
                st_wmask   = 8'h0F << ex_lane;
            end
            default: begin
                ex_aligned = (ex_lane == 3'b000);
            end
        endcase
    end

    // Select the addressed lane of the read doubleword and extend it
    always_comb begin
        rd_shifted = mem_rdata_i >> {lane_q, 3'b000};
        case (funct3_q)
            3'b000:  ld_data = {{56{rd_shifted[7]}}, rd_shifted[7:0]};
            3'b100:  ld_data = {56'd0, rd_shifted[7:0]};
            3'b001:  ld_data = {{48{rd_shifted[15]}}, rd_shifted[15:0]};
            3'b101:  ld_data = {48'd0, rd_shifted[15:0]};
            3'b010:  ld_data = {{32{rd_shifted[31]}}, rd_shifted[31:0]};
            3'b110:  ld_data = {32'd0, rd_shifted[31:0]};
            default: ld_data = mem_rdata_i;
        endcase
    end

    // Next-state logic: accept from EX in IDLE, wait for mem_ready in BUS
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        is_load_d  = is_load_q;
        funct3_d   = funct3_q;
        lane_d     = lane_q;
        rd_d       = rd_q;
        mis_d      = 1'b0;
        wb_valid_d = 1'b0;
        wb_rd_d    = 5'd0;
        wb_data_d  = '0;
        unique case (state_q)
            StIdle: begin
                if (ex_valid_i) begin
                    if (ex_load_i || ex_store_i) begin
                        if (ex_aligned) begin
                            state_d   = StBus;
                            req_d     = 1'b1;
                            // Load wins when both flags are set
                            we_d      = ~ex_load_i;
                            addr_d    = {ex_alu_res_i[XLEN-1:3], 3'b000};
                            wdata_d   = ex_load_i ? '0 : st_wdata;
                            wmask_d   = ex_load_i ? 8'h00 : st_wmask;
                            is_load_d = ex_load_i;
                            funct3_d  = ex_funct3_i;
                            lane_d    = ex_lane;
                            rd_d      = ex_rd_i;
                        end else begin
                            mis_d = 1'b1;
                        end
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = ex_rd_i;
                        wb_data_d  = ex_alu_res_i;
                    end
                end
            end
            StBus: begin
                if (mem_ready_i) begin
                    state_d = StIdle;
                    req_d   = 1'b0;
                    if (is_load_q) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_data_d  = ld_data;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous reset; reset abandons any open access
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= 8'h00;
            is_load_q  <= 1'b0;
            funct3_q   <= 3'd0;
            lane_q     <= 3'd0;
            rd_q       <= 5'd0;
            mis_q      <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            is_load_q  <= is_load_d;
            funct3_q   <= funct3_d;
            lane_q     <= lane_d;
            rd_q       <= rd_d;
            mis_q      <= mis_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
        end
    end

    // Outputs are straight register decodes; wb_rd_q is already 0 without a result
    always_comb begin
        stall_o        = (state_q == StBus);
        load_pending_o = (state_q == StBus) && is_load_q;
        mem_req_o      = req_q;
        mem_we_o       = we_q;
        mem_addr_o     = addr_q;
        mem_wdata_o    = wdata_q;
        mem_wmask_o    = wmask_q;
        misaligned_o   = mis_q;
        fwd_rd_o       = wb_rd_q;
        fwd_res_o      = wb_data_q;
        wb_valid_o     = wb_valid_q;
        wb_rd_o        = wb_rd_q;
        wb_data_o      = wb_data_q;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a table of single transactions plus hand
// sequences for back-to-back issue and reset in the middle of a bus access.
module tb_mem_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ex_valid_i;
    logic [4:0]  ex_rd_i;
    logic [63:0] ex_alu_res_i;
    logic        ex_load_i;
    logic        ex_store_i;
    logic [2:0]  ex_funct3_i;
    logic [63:0] ex_store_value_i;
    logic        stall_o;
    logic        load_pending_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [63:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic [7:0]  mem_wmask_o;
    logic        mem_ready_i;
    logic [63:0] mem_rdata_i;
    logic        misaligned_o;
    logic [4:0]  fwd_rd_o;
    logic [63:0] fwd_res_o;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [63:0] wb_data_o;

    int checks = 0;
    int errors = 0;

    mem_stage #(.XLEN(64)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .ex_valid_i       (ex_valid_i),
        .ex_rd_i          (ex_rd_i),
        .ex_alu_res_i     (ex_alu_res_i),
        .ex_load_i        (ex_load_i),
        .ex_store_i       (ex_store_i),
        .ex_funct3_i      (ex_funct3_i),
        .ex_store_value_i (ex_store_value_i),
        .stall_o          (stall_o),
        .load_pending_o   (load_pending_o),
        .mem_req_o        (mem_req_o),
        .mem_we_o         (mem_we_o),
        .mem_addr_o       (mem_addr_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_wmask_o      (mem_wmask_o),
        .mem_ready_i      (mem_ready_i),
        .mem_rdata_i      (mem_rdata_i),
        .misaligned_o     (misaligned_o),
        .fwd_rd_o         (fwd_rd_o),
        .fwd_res_o        (fwd_res_o),
        .wb_valid_o       (wb_valid_o),
        .wb_rd_o          (wb_rd_o),
        .wb_data_o        (wb_data_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] val;
        logic [4:0]  rd;
        logic [63:0] rdata;
        int          busy;      // BUS cycles before completion
        logic        mis;
        logic [63:0] exp_addr;
        logic [7:0]  exp_wmask;
        logic [63:0] exp_wdata;
        logic        exp_wbv;
        logic [4:0]  exp_rd;
        logic [63:0] exp_data;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid_i       = 1'b0;
        ex_rd_i          = 5'd0;
        ex_alu_res_i     = 64'd0;
        ex_load_i        = 1'b0;
        ex_store_i       = 1'b0;
        ex_funct3_i      = 3'd0;
        ex_store_value_i = 64'd0;
        mem_ready_i      = 1'b0;
        mem_rdata_i      = 64'd0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".stall"}, {63'd0, stall_o}, 64'd0);
        chk({tag, ".load_pending"}, {63'd0, load_pending_o}, 64'd0);
        chk({tag, ".mem_req"}, {63'd0, mem_req_o}, 64'd0);
        chk({tag, ".mem_we"}, {63'd0, mem_we_o}, 64'd0);
        chk({tag, ".mem_addr"}, mem_addr_o, 64'd0);
        chk({tag, ".mem_wdata"}, mem_wdata_o, 64'd0);
        chk({tag, ".mem_wmask"}, {56'd0, mem_wmask_o}, 64'd0);
        chk({tag, ".misaligned"}, {63'd0, misaligned_o}, 64'd0);
        chk({tag, ".fwd_rd"}, {59'd0, fwd_rd_o}, 64'd0);
        chk({tag, ".fwd_res"}, fwd_res_o, 64'd0);
        chk({tag, ".wb_valid"}, {63'd0, wb_valid_o}, 64'd0);
        chk({tag, ".wb_rd"}, {59'd0, wb_rd_o}, 64'd0);
        chk({tag, ".wb_data"}, wb_data_o, 64'd0);
    endtask

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] val,
                         input logic [4:0] rd);
        ex_valid_i       = 1'b1;
        ex_load_i        = ld;
        ex_store_i       = st;
        ex_funct3_i      = f3;
        ex_alu_res_i     = addr;
        ex_store_value_i = val;
        ex_rd_i          = rd;
    endtask

    task automatic run_vec(input vec_t v);
        int stall_cnt;
        issue(v.ld, v.st, v.f3, v.addr, v.val, v.rd);
        tick();
        ex_valid_i = 1'b0;
        if (v.mis) begin
            chk({v.name, ".misaligned"}, {63'd0, misaligned_o}, 64'd1);
            chk({v.name, ".mem_req"}, {63'd0, mem_req_o}, 64'd0);
            chk({v.name, ".stall"}, {63'd0, stall_o}, 64'd0);
            chk({v.name, ".wb_valid"}, {63'd0, wb_valid_o}, 64'd0);
            tick();
            chk({v.name, ".mis_pulse_end"}, {63'd0, misaligned_o}, 64'd0);
            chk({v.name, ".mem_req_after"}, {63'd0, mem_req_o}, 64'd0);
        end else if (v.ld || v.st) begin
            chk({v.name, ".mem_req"}, {63'd0, mem_req_o}, 64'd1);
            chk({v.name, ".mem_we"}, {63'd0, mem_we_o}, {63'd0, ~v.ld});
            chk({v.name, ".mem_addr"}, mem_addr_o, v.exp_addr);
            chk({v.name, ".fwd_rd_busy"}, {59'd0, fwd_rd_o}, 64'd0);
            chk({v.name, ".wb_valid_busy"}, {63'd0, wb_valid_o}, 64'd0);
            if (!v.ld) begin
                chk({v.name, ".mem_wmask"}, {56'd0, mem_wmask_o}, {56'd0, v.exp_wmask});
                chk({v.name, ".mem_wdata"}, mem_wdata_o, v.exp_wdata);
            end
            stall_cnt = 0;
            for (int i = 0; i < v.busy; i++) begin
                if (stall_o) stall_cnt++;
                chk({v.name, ".load_pending"}, {63'd0, load_pending_o}, {63'd0, v.ld});
                chk({v.name, ".addr_hold"}, mem_addr_o, v.exp_addr);
                if (i == v.busy - 1) begin
                    mem_ready_i = 1'b1;
                    mem_rdata_i = v.rdata;
                end
                tick();
            end
            mem_ready_i = 1'b0;
            mem_rdata_i = 64'd0;
            chk({v.name, ".stall_cycles"}, 64'(stall_cnt), 64'(v.busy));
            chk({v.name, ".mem_req_done"}, {63'd0, mem_req_o}, 64'd0);
            chk({v.name, ".stall_done"}, {63'd0, stall_o}, 64'd0);
            chk({v.name, ".wb_valid"}, {63'd0, wb_valid_o}, {63'd0, v.exp_wbv});
            chk({v.name, ".wb_rd"}, {59'd0, wb_rd_o}, {59'd0, v.exp_rd});
            chk({v.name, ".fwd_rd"}, {59'd0, fwd_rd_o}, {59'd0, v.exp_rd});
            if (v.exp_wbv) begin
                chk({v.name, ".wb_data"}, wb_data_o, v.exp_data);
                chk({v.name, ".fwd_res"}, fwd_res_o, v.exp_data);
            end
        end else begin
            chk({v.name, ".wb_valid"}, {63'd0, wb_valid_o}, 64'd1);
            chk({v.name, ".wb_rd"}, {59'd0, wb_rd_o}, {59'd0, v.exp_rd});
            chk({v.name, ".fwd_rd"}, {59'd0, fwd_rd_o}, {59'd0, v.exp_rd});
            chk({v.name, ".fwd_res"}, fwd_res_o, v.exp_data);
            chk({v.name, ".wb_data"}, wb_data_o, v.exp_data);
            chk({v.name, ".stall"}, {63'd0, stall_o}, 64'd0);
        end
        tick();
    endtask

    vec_t vecs[$];

    initial begin
        //        name      ld    st    f3      addr         val                    rd     rdata                  busy mis   exp_addr     wmask  wdata                  wbv   rd     data
        vecs.push_back('{"alu",   1'b0, 1'b0, 3'b000, 64'h1234, 64'h0, 5'd5, 64'h0, 0, 1'b0, 64'h0, 8'h00, 64'h0, 1'b1, 5'd5, 64'h1234});
        vecs.push_back('{"lb",    1'b1, 1'b0, 3'b000, 64'h1003, 64'h0, 5'd10, 64'h00000000_80FF0000, 3, 1'b0, 64'h1000, 8'h00, 64'h0, 1'b1, 5'd10, 64'hFFFFFFFF_FFFFFF80});
        vecs.push_back('{"lbu",   1'b1, 1'b0, 3'b100, 64'h1003, 64'h0, 5'd11, 64'h00000000_80FF0000, 3, 1'b0, 64'h1000, 8'h00, 64'h0, 1'b1, 5'd11, 64'h80});
        vecs.push_back('{"sh",    1'b0, 1'b1, 3'b001, 64'h2006, 64'hABCD, 5'd12, 64'h0, 1, 1'b0, 64'h2000, 8'hC0, 64'hABCDABCD_ABCDABCD, 1'b0, 5'd0, 64'h0});
        vecs.push_back('{"lw_mis",1'b1, 1'b0, 3'b010, 64'h3002, 64'h0, 5'd4, 64'h0, 0, 1'b1, 64'h0, 8'h00, 64'h0, 1'b0, 5'd0, 64'h0});
        vecs.push_back('{"lwu_r0",1'b1, 1'b0, 3'b110, 64'h5004, 64'h0, 5'd0, 64'h89ABCDEF_01234567, 2, 1'b0, 64'h5000, 8'h00, 64'h0, 1'b1, 5'd0, 64'h00000000_89ABCDEF});
        vecs.push_back('{"lh",    1'b1, 1'b0, 3'b001, 64'h1006, 64'h0, 5'd13, 64'h8001_0000_0000_0000, 1, 1'b0, 64'h1000, 8'h00, 64'h0, 1'b1, 5'd13, 64'hFFFFFFFF_FFFF8001});
        vecs.push_back('{"lw",    1'b1, 1'b0, 3'b010, 64'h1004, 64'h0, 5'd14, 64'h89ABCDEF_01234567, 1, 1'b0, 64'h1000, 8'h00, 64'h0, 1'b1, 5'd14, 64'hFFFFFFFF_89ABCDEF});
        vecs.push_back('{"ld",    1'b1, 1'b0, 3'b011, 64'h4008, 64'h0, 5'd15, 64'h01234567_89ABCDEF, 2, 1'b0, 64'h4008, 8'h00, 64'h0, 1'b1, 5'd15, 64'h01234567_89ABCDEF});
        vecs.push_back('{"f3_111",1'b1, 1'b0, 3'b111, 64'h4010, 64'h0, 5'd16, 64'hFEDCBA98_76543210, 1, 1'b0, 64'h4010, 8'h00, 64'h0, 1'b1, 5'd16, 64'hFEDCBA98_76543210});
        vecs.push_back('{"sb",    1'b0, 1'b1, 3'b000, 64'h2001, 64'h11223344_5566775A, 5'd17, 64'h0, 2, 1'b0, 64'h2000, 8'h02, 64'h5A5A5A5A_5A5A5A5A, 1'b0, 5'd0, 64'h0});
        vecs.push_back('{"sw",    1'b0, 1'b1, 3'b010, 64'h2004, 64'hDEADBEEF, 5'd18, 64'h0, 1, 1'b0, 64'h2000, 8'hF0, 64'hDEADBEEF_DEADBEEF, 1'b0, 5'd0, 64'h0});
        vecs.push_back('{"sd",    1'b0, 1'b1, 3'b011, 64'h2008, 64'h01234567_89ABCDEF, 5'd19, 64'h0, 1, 1'b0, 64'h2008, 8'hFF, 64'h01234567_89ABCDEF, 1'b0, 5'd0, 64'h0});
        vecs.push_back('{"sd_mis",1'b0, 1'b1, 3'b011, 64'h2004, 64'h0, 5'd20, 64'h0, 0, 1'b1, 64'h0, 8'h00, 64'h0, 1'b0, 5'd0, 64'h0});
        vecs.push_back('{"lh_mis",1'b1, 1'b0, 3'b001, 64'h1001, 64'h0, 5'd21, 64'h0, 0, 1'b1, 64'h0, 8'h00, 64'h0, 1'b0, 5'd0, 64'h0});
        vecs.push_back('{"ld_st", 1'b1, 1'b1, 3'b000, 64'h1000, 64'h0, 5'd22, 64'h00000000_000000FF, 1, 1'b0, 64'h1000, 8'h00, 64'h0, 1'b1, 5'd22, 64'hFFFFFFFF_FFFFFFFF});

        idle_inputs();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        check_all_zero("reset");

        // Back-to-back ALU results, one per cycle, never stalled
        issue(1'b0, 1'b0, 3'd0, 64'h66, 64'd0, 5'd6);
        tick();
        chk("b2b.rd6", {59'd0, wb_rd_o}, 64'd6);
        chk("b2b.res6", fwd_res_o, 64'h66);
        chk("b2b.stall6", {63'd0, stall_o}, 64'd0);
        issue(1'b0, 1'b0, 3'd0, 64'h77, 64'd0, 5'd7);
        tick();
        chk("b2b.valid7", {63'd0, wb_valid_o}, 64'd1);
        chk("b2b.fwd_rd7", {59'd0, fwd_rd_o}, 64'd7);
        chk("b2b.res7", wb_data_o, 64'h77);
        ex_valid_i = 1'b0;
        tick();
        chk("b2b.idle_valid", {63'd0, wb_valid_o}, 64'd0);
        chk("b2b.idle_fwd_rd", {59'd0, fwd_rd_o}, 64'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset during the second BUS cycle of a load abandons the access
        issue(1'b1, 1'b0, 3'b011, 64'h4000, 64'd0, 5'd9);
        tick();
        ex_valid_i = 1'b0;
        chk("rstmid.req", {63'd0, mem_req_o}, 64'd1);
        tick();
        chk("rstmid.stall", {63'd0, stall_o}, 64'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check_all_zero("rstmid");
        mem_ready_i = 1'b1;
        mem_rdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        mem_ready_i = 1'b0;
        chk("rstmid.late_wb", {63'd0, wb_valid_o}, 64'd0);
        chk("rstmid.late_fwd", {59'd0, fwd_rd_o}, 64'd0);
        chk("rstmid.late_req", {63'd0, mem_req_o}, 64'd0);
        issue(1'b0, 1'b0, 3'd0, 64'hCAFE, 64'd0, 5'd3);
        tick();
        ex_valid_i = 1'b0;
        chk("rstmid.alu_valid", {63'd0, wb_valid_o}, 64'd1);
        chk("rstmid.alu_rd", {59'd0, wb_rd_o}, 64'd3);
        chk("rstmid.alu_res", fwd_res_o, 64'hCAFE);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
